// File: rtl/switch_debounce_events.sv
// Push-switch conditioning: per-switch synchroniser, debounce FSM, edge pulses,
// LED toggle on release, and a single-entry valid/ready event register fed from
// per-switch pending bits, drained lowest index first.
module switch_debounce_events #(
  parameter  int NUM_SW         = 4,
  parameter  int DEBOUNCE_LIMIT = 250000,
  parameter  int SYNC_STAGES    = 2,
  localparam int IDW            = (NUM_SW > 1) ? $clog2(NUM_SW) : 1,
  localparam int CW             = $clog2(DEBOUNCE_LIMIT)
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_SW-1:0] i_Switch,
  output logic [NUM_SW-1:0] o_Switch,
  output logic [NUM_SW-1:0] o_Press,
  output logic [NUM_SW-1:0] o_Release,
  output logic [NUM_SW-1:0] o_LED,
  output logic              o_Evt_Valid,
  output logic [IDW-1:0]    o_Evt_Id,
  output logic              o_Evt_Press,
  input  logic              i_Evt_Ready,
  output logic              o_Overflow,
  input  logic              i_Ovf_Clr
);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } db_state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [NUM_SW-1:0] sync_r [SYNC_STAGES];
  logic [NUM_SW-1:0] sync_s;

  db_state_t         state_r     [NUM_SW];
  db_state_t         state_nxt_s [NUM_SW];
  logic [CW-1:0]     cnt_r       [NUM_SW];
  logic [CW-1:0]     cnt_nxt_s   [NUM_SW];
  logic [NUM_SW-1:0] qual_s;

  logic [NUM_SW-1:0] pend_r;
  logic [NUM_SW-1:0] ptype_r;
  logic [NUM_SW-1:0] pend_nxt_s;
  logic [NUM_SW-1:0] ptype_nxt_s;
  logic [NUM_SW-1:0] lowest_s;
  logic [NUM_SW-1:0] take_s;
  logic              load_s;
  logic              found_s;
  logic              pick_type_s;
  logic [IDW-1:0]    pick_idx_s;
  logic              ovf_set_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Plain flop chain per switch to resolve metastability on the raw pads.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= '0;
      end
    end else begin
      sync_r[0] <= i_Switch;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  // Debounce next-state: a new level must persist DEBOUNCE_LIMIT evaluations in a row.
  always_comb begin
    for (int n = 0; n < NUM_SW; n++) begin
      state_nxt_s[n] = state_r[n];
      cnt_nxt_s[n]   = cnt_r[n];
      qual_s[n]      = 1'b0;
      case (state_r[n])
        ST_STABLE: begin
          if (sync_s[n] != o_Switch[n]) begin
            state_nxt_s[n] = ST_COUNT;
            cnt_nxt_s[n]   = CNT_ONE;
          end else begin
            state_nxt_s[n] = ST_STABLE;
            cnt_nxt_s[n]   = '0;
          end
        end
        ST_COUNT: begin
          if (sync_s[n] == o_Switch[n]) begin
            // glitch: back to the old level before qualifying
            state_nxt_s[n] = ST_STABLE;
            cnt_nxt_s[n]   = '0;
          end else if (cnt_r[n] == CNT_LAST) begin
            qual_s[n]      = 1'b1;
            state_nxt_s[n] = ST_STABLE;
            cnt_nxt_s[n]   = '0;
          end else begin
            cnt_nxt_s[n]   = cnt_r[n] + CNT_ONE;
          end
        end
        default: begin
          state_nxt_s[n] = ST_STABLE;
          cnt_nxt_s[n]   = '0;
        end
      endcase
    end
  end

  // Debounce state and counter registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int n = 0; n < NUM_SW; n++) begin
        state_r[n] <= ST_STABLE;
        cnt_r[n]   <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_SW; n++) begin
        state_r[n] <= state_nxt_s[n];
        cnt_r[n]   <= cnt_nxt_s[n];
      end
    end
  end

  // Clean level, edge pulses and release-driven LED toggle.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Switch  <= '0;
      o_Press   <= '0;
      o_Release <= '0;
      o_LED     <= '0;
    end else begin
      o_Switch  <= o_Switch ^ qual_s;
      o_Press   <= qual_s & sync_s;
      o_Release <= qual_s & ~sync_s;
      o_LED     <= o_LED ^ o_Release;
    end
  end

  // Pick the lowest pending switch and work out pending/overflow updates.
  always_comb begin
    load_s      = ~o_Evt_Valid | i_Evt_Ready;
    found_s     = |pend_r;
    lowest_s    = pend_r & (~pend_r + NUM_SW'(1));
    take_s      = load_s ? lowest_s : '0;
    pick_type_s = |(lowest_s & ptype_r);
    pick_idx_s  = '0;
    ovf_set_s   = 1'b0;
    pend_nxt_s  = pend_r;
    ptype_nxt_s = ptype_r;
    for (int n = 0; n < NUM_SW; n++) begin
      if (lowest_s[n]) begin
        pick_idx_s = IDW'(n);
      end else begin
        pick_idx_s = pick_idx_s;
      end
      if (qual_s[n]) begin
        // an edge landing on a still-queued entry that is not leaving now loses it
        ovf_set_s      = ovf_set_s | (pend_r[n] & ~take_s[n]);
        pend_nxt_s[n]  = 1'b1;
        ptype_nxt_s[n] = sync_s[n];
      end else if (take_s[n]) begin
        pend_nxt_s[n]  = 1'b0;
      end else begin
        pend_nxt_s[n]  = pend_r[n];
      end
    end
  end

  // Pending bits and their press/release type.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      pend_r  <= '0;
      ptype_r <= '0;
    end else begin
      pend_r  <= pend_nxt_s;
      ptype_r <= ptype_nxt_s;
    end
  end

  // Output event register; holds while the consumer stalls.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Evt_Valid <= 1'b0;
      o_Evt_Id    <= '0;
      o_Evt_Press <= 1'b0;
    end else if (load_s) begin
      if (found_s) begin
        o_Evt_Valid <= 1'b1;
        o_Evt_Id    <= pick_idx_s;
        o_Evt_Press <= pick_type_s;
      end else begin
        o_Evt_Valid <= 1'b0;
      end
    end else begin
      o_Evt_Valid <= o_Evt_Valid;
    end
  end

  // Sticky overflow flag; a new overflow beats a same-cycle clear.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Overflow <= 1'b0;
    end else if (ovf_set_s) begin
      o_Overflow <= 1'b1;
    end else if (i_Ovf_Clr) begin
      o_Overflow <= 1'b0;
    end else begin
      o_Overflow <= o_Overflow;
    end
  end

endmodule
